// File: rtl/instr_stat_pkg.sv
// Shared types, default geometry and counter sizing for the bit-serial L/F instruction staticisor.
package instr_stat_pkg;

  typedef enum logic {StIdle, StShift} state_e;

  localparam int unsigned DefWordBits = 32;
  localparam int unsigned DefLBits    = 5;
  localparam int unsigned DefLLsb     = 0;
  localparam int unsigned DefFBits    = 3;
  localparam int unsigned DefFLsb     = 13;

  // Digit counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned word_bits);
    return (word_bits > 1) ? $clog2(word_bits) : 1;
  endfunction

endpackage

// File: rtl/instr_stat_if.sv
// Store-side bus of the staticisor: serial digit stream, halt/manual controls, static L/F levels.
interface instr_stat_if #(
  parameter int unsigned L_BITS = 5,
  parameter int unsigned F_BITS = 3
) ();
  logic              beat_start;
  logic              digit;
  logic              scan;
  logic              ha;
  logic              man_en;
  logic [L_BITS-1:0] man_l;
  logic [F_BITS-1:0] man_f;
  logic [L_BITS-1:0] l1;
  logic [L_BITS-1:0] l0;
  logic [F_BITS-1:0] f1;
  logic [F_BITS-1:0] f0;
  logic              valid;
  logic              busy;
  logic              err;

  modport master (
    output beat_start, digit, scan, ha, man_en, man_l, man_f,
    input  l1, l0, f1, f0, valid, busy, err
  );

  modport slave (
    input  beat_start, digit, scan, ha, man_en, man_l, man_f,
    output l1, l0, f1, f0, valid, busy, err
  );
endinterface

// File: rtl/instr_stat_field.sv
// One staticised field: shadow register filled from the digit stream plus the static output register.
module instr_stat_field #(
  parameter int unsigned BITS = 5,
  parameter int unsigned LSB  = 0,
  parameter int unsigned CW   = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            we_i,
  input  logic [CW-1:0]   idx_i,
  input  logic            digit_i,
  input  logic            commit_i,
  input  logic            load_i,
  input  logic [BITS-1:0] load_val_i,
  output logic [BITS-1:0] q_o
);

  logic [BITS-1:0] shadow_d, shadow_q;
  logic [BITS-1:0] out_d, out_q;

  always_comb begin
    shadow_d = clr_i ? '0 : shadow_q;
    for (int i = 0; i < int'(BITS); i++) begin
      if (we_i && (idx_i == CW'(LSB + i))) shadow_d[i] = digit_i;
    end
    out_d = out_q;
    // Commit takes shadow_d so a field ending on the last digit of the word is complete.
    if (commit_i)    out_d = shadow_d;
    else if (load_i) out_d = load_val_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      out_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      out_q    <= out_d;
    end
  end

  assign q_o = out_q;

endmodule

// File: rtl/instr_stat.sv
// Bit-serial L/F instruction staticiser with halt abort and overrun detection.
// Optional manual load path enabled by defining INSTR_STAT_MANUAL_EN.
module instr_stat
  import instr_stat_pkg::*;
#(
  parameter int unsigned WORD_BITS = DefWordBits,
  parameter int unsigned L_BITS    = DefLBits,
  parameter int unsigned L_LSB     = DefLLsb,
  parameter int unsigned F_BITS    = DefFBits,
  parameter int unsigned F_LSB     = DefFLsb
) (
  input logic         clk,
  input logic         rst,
  instr_stat_if.slave bus
);

  localparam int unsigned CW = cnt_width(WORD_BITS);

`ifdef INSTR_STAT_MANUAL_EN
  localparam bit ManualEn = 1'b1;
`else
  localparam bit ManualEn = 1'b0;
`endif

  if (L_LSB + L_BITS > WORD_BITS) begin : g_l_range
    $error("instr_stat: L field lies outside the word");
  end
  if (F_LSB + F_BITS > WORD_BITS) begin : g_f_range
    $error("instr_stat: F field lies outside the word");
  end
  if ((L_LSB < F_LSB + F_BITS) && (F_LSB < L_LSB + L_BITS)) begin : g_overlap
    $error("instr_stat: L and F fields overlap");
  end

  state_e        state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          valid_d, valid_q;
  logic          err_d, err_q;
  logic          we, clr, commit, man_load;
  logic [CW-1:0] idx;
  logic          man_req;

  assign man_req = ManualEn & bus.man_en & bus.ha;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    we       = 1'b0;
    clr      = 1'b0;
    commit   = 1'b0;
    man_load = 1'b0;
    idx      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.beat_start && bus.scan && !bus.ha) begin
          clr     = 1'b1;
          we      = 1'b1;
          idx     = '0;
          cnt_d   = CW'(1);
          state_d = StShift;
        end else if (man_req) begin
          man_load = 1'b1;
          valid_d  = 1'b1;
        end
      end
      StShift: begin
        if (bus.beat_start) begin
          // Early beat: previous word is lost, the new one may restart immediately.
          err_d = 1'b1;
          clr   = 1'b1;
          if (bus.scan && !bus.ha) begin
            we    = 1'b1;
            idx   = '0;
            cnt_d = CW'(1);
          end else begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end else if (bus.ha) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          we    = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WORD_BITS - 1)) begin
            commit  = 1'b1;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  logic [L_BITS-1:0] l_q;
  logic [F_BITS-1:0] f_q;

  instr_stat_field #(
    .BITS (L_BITS),
    .LSB  (L_LSB),
    .CW   (CW)
  ) u_l_field (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (clr),
    .we_i       (we),
    .idx_i      (idx),
    .digit_i    (bus.digit),
    .commit_i   (commit),
    .load_i     (man_load),
    .load_val_i (bus.man_l),
    .q_o        (l_q)
  );

  instr_stat_field #(
    .BITS (F_BITS),
    .LSB  (F_LSB),
    .CW   (CW)
  ) u_f_field (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (clr),
    .we_i       (we),
    .idx_i      (idx),
    .digit_i    (bus.digit),
    .commit_i   (commit),
    .load_i     (man_load),
    .load_val_i (bus.man_f),
    .q_o        (f_q)
  );

  assign bus.l1    = l_q;
  assign bus.l0    = ~l_q;
  assign bus.f1    = f_q;
  assign bus.f0    = ~f_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state_q == StShift);
  assign bus.err   = err_q;

endmodule
